vin_adcscan: RTL and testbench

//  Parametrised round-robin sequencer for an Avalon-ST ADC core (MAX10 modular ADC or equivalent).

---
 rtl/vin_adcscan_pkg.sv | 23 ++
 rtl/vin_adcscan_if.sv | 25 ++
 rtl/vin_adcscan_acc.sv | 48 ++++
 rtl/vin_adcscan.sv | 152 +++++++++++++++
 tb/tb_vin_adcscan.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vin_adcscan_pkg.sv
// Shared types and constants for the round-robin ADC scan sequencer.
package vin_adcscan_pkg;

    localparam int CH_HW_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vin_adcscan_if.sv
// Avalon-ST command/response pair between the scan sequencer and the ADC core.
interface vin_adcscan_if
    import vin_adcscan_pkg::*;
#(
    parameter int DATA_W = 12
);
    logic                cmd_valid;
    logic [CH_HW_W-1:0]  cmd_channel;
    logic                cmd_sop;
    logic                cmd_eop;
    logic                cmd_ready;
    logic                rsp_valid;
    logic [CH_HW_W-1:0]  rsp_channel;
    logic [DATA_W-1:0]   rsp_data;

    modport master (
        output cmd_valid, cmd_channel, cmd_sop, cmd_eop,
        input  cmd_ready, rsp_valid, rsp_channel, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_channel, cmd_sop, cmd_eop,
        output cmd_ready, rsp_valid, rsp_channel, rsp_data
    );
endinterface

// File: rtl/vin_adcscan_acc.sv
// Oversampling accumulator: sums 2**AVG_LOG2 samples, flags the completing add.
module vin_adcscan_acc #(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 2,
    localparam int ACC_W   = DATA_W + AVG_LOG2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add,
    input  logic [DATA_W-1:0] din,
    output logic [ACC_W-1:0]  sum,
    output logic              done
);
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last;

    assign last = (cnt_q == CNT_W'((1 << AVG_LOG2) - 1));
    assign sum  = acc_q + ACC_W'(din);
    assign done = add && last;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        // the completing add hands its sum to the caller and restarts the window
        if (clr || (add && last)) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (add) begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vin_adcscan.sv
// Round-robin ADC scan sequencer: one command in flight, per-channel oversampled results.
//   state | meaning
//   IDLE  | scanning stopped, results held
//   ISSUE | command for channel FIRST_CH+idx presented until accepted
//   WAIT  | command accepted, awaiting matching response or timeout
module vin_adcscan
    import vin_adcscan_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int FIRST_CH = 1,
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 2,
    parameter int OUT_W    = 16,
    parameter int TIMEOUT  = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    err_clr,
    vin_adcscan_if.master           adc,
    output logic [NUM_CH*OUT_W-1:0] adc_flat,
    output logic [NUM_CH-1:0]       ch_strobe,
    output logic                    scan_done,
    output logic                    timeout_err
);
    localparam int IDX_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
    localparam int TMO_W = (clog2(TIMEOUT + 1) > 0) ? clog2(TIMEOUT + 1) : 1;
    localparam int ACC_W = DATA_W + AVG_LOG2;

    if (NUM_CH < 1 || NUM_CH > 16 || AVG_LOG2 < 0 || AVG_LOG2 > 4 ||
        OUT_W < DATA_W + AVG_LOG2) begin : g_param_err
        $error("vin_adcscan: illegal parameter combination");
    end

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [OUT_W-1:0]   slot_q [NUM_CH];
    logic [OUT_W-1:0]   slot_d [NUM_CH];
    logic [NUM_CH-1:0]  strobe_q, strobe_d;
    logic               scan_done_q, scan_done_d;
    logic               err_q, err_d;

    logic               acc_add, acc_clr, acc_done;
    logic [ACC_W-1:0]   acc_sum;
    logic [CH_HW_W-1:0] ch_hw;
    logic               rsp_match;
    logic               cmd_valid;

    assign ch_hw     = CH_HW_W'(FIRST_CH) + CH_HW_W'(idx_q);
    // stale responses from a dropped or reset command fail this compare
    assign rsp_match = adc.rsp_valid && (adc.rsp_channel == ch_hw);

    vin_adcscan_acc #(
        .DATA_W   (DATA_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_acc (
        .clk  (clk),
        .rst  (rst),
        .clr  (acc_clr),
        .add  (acc_add),
        .din  (adc.rsp_data),
        .sum  (acc_sum),
        .done (acc_done)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        slot_d      = slot_q;
        strobe_d    = '0;
        scan_done_d = 1'b0;
        err_d       = err_q && !err_clr;
        acc_add     = 1'b0;
        acc_clr     = 1'b0;
        cmd_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) state_d = ISSUE;
            end
            ISSUE: begin
                cmd_valid = 1'b1;
                if (adc.cmd_ready) begin
                    state_d = WAIT;
                    tmo_d   = '0;
                end
            end
            WAIT: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (rsp_match) begin
                    acc_add = 1'b1;
                    if (acc_done) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (IDX_W'(i) == idx_q) begin
                                slot_d[i]   = OUT_W'(acc_sum);
                                strobe_d[i] = 1'b1;
                            end
                        end
                        if (idx_q == IDX_W'(NUM_CH - 1)) begin
                            idx_d       = '0;
                            scan_done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                    state_d = enable ? ISSUE : IDLE;
                end else if (tmo_q == TMO_W'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    acc_clr = 1'b1;
                    state_d = enable ? ISSUE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            tmo_q       <= '0;
            strobe_q    <= '0;
            scan_done_q <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) slot_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            strobe_q    <= strobe_d;
            scan_done_q <= scan_done_d;
            err_q       <= err_d;
            slot_q      <= slot_d;
        end
    end

    assign adc.cmd_valid   = cmd_valid;
    assign adc.cmd_channel = cmd_valid ? ch_hw : '0;
    assign adc.cmd_sop     = cmd_valid;
    assign adc.cmd_eop     = cmd_valid;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
        assign adc_flat[g*OUT_W +: OUT_W] = slot_q[g];
    end

    assign ch_strobe   = strobe_q;
    assign scan_done   = scan_done_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_vin_adcscan.sv
// Directed bench: an oversampling instance (3 ch, x4, timeout 15) and a raw passthrough instance (4 ch).
module tb_vin_adcscan;

    logic clk;
    logic rst;
    logic enable_a, err_clr_a;
    logic enable_b, err_clr_b;

    logic [47:0] adc_flat_a;
    logic [2:0]  ch_strobe_a;
    logic        scan_done_a, timeout_err_a;
    logic [63:0] adc_flat_b;
    logic [3:0]  ch_strobe_b;
    logic        scan_done_b, timeout_err_b;

    int n_chk;
    int n_fail;

    vin_adcscan_if #(.DATA_W(12)) a_if ();
    vin_adcscan_if #(.DATA_W(12)) b_if ();

    vin_adcscan #(
        .NUM_CH(3), .FIRST_CH(1), .DATA_W(12), .AVG_LOG2(2), .OUT_W(16), .TIMEOUT(15)
    ) dut_a (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable_a),
        .err_clr     (err_clr_a),
        .adc         (a_if),
        .adc_flat    (adc_flat_a),
        .ch_strobe   (ch_strobe_a),
        .scan_done   (scan_done_a),
        .timeout_err (timeout_err_a)
    );

    vin_adcscan #(
        .NUM_CH(4), .FIRST_CH(1), .DATA_W(12), .AVG_LOG2(0), .OUT_W(16), .TIMEOUT(15)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable_b),
        .err_clr     (err_clr_b),
        .adc         (b_if),
        .adc_flat    (adc_flat_b),
        .ch_strobe   (ch_strobe_b),
        .scan_done   (scan_done_b),
        .timeout_err (timeout_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_wait_cmd(input logic [4:0] ch);
        for (int i = 0; i < 40 && !a_if.cmd_valid; i++) tick();
        chk("a_cmd_valid", a_if.cmd_valid, 1);
        chk("a_cmd_channel", a_if.cmd_channel, ch);
    endtask

    task automatic a_accept(input logic [4:0] ch);
        a_wait_cmd(ch);
        a_if.cmd_ready = 1'b1;
        tick();
        a_if.cmd_ready = 1'b0;
    endtask

    task automatic a_rsp(input logic [4:0] ch, input logic [11:0] data);
        a_if.rsp_valid   = 1'b1;
        a_if.rsp_channel = ch;
        a_if.rsp_data    = data;
        tick();
        a_if.rsp_valid   = 1'b0;
    endtask

    task automatic a_sample(input logic [4:0] ch, input logic [11:0] data);
        a_accept(ch);
        a_rsp(ch, data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1;
        enable_a = 1'b0; err_clr_a = 1'b0;
        enable_b = 1'b0; err_clr_b = 1'b0;
        a_if.cmd_ready = 1'b0; a_if.rsp_valid = 1'b0; a_if.rsp_channel = '0; a_if.rsp_data = '0;
        b_if.cmd_ready = 1'b0; b_if.rsp_valid = 1'b0; b_if.rsp_channel = '0; b_if.rsp_data = '0;
        repeat (3) tick();

        chk("rst_cmd_valid", a_if.cmd_valid, 0);
        chk("rst_cmd_channel", a_if.cmd_channel, 0);
        chk("rst_cmd_sop", a_if.cmd_sop, 0);
        chk("rst_flat", adc_flat_a, 0);
        chk("rst_strobe", ch_strobe_a, 0);
        chk("rst_scan_done", scan_done_a, 0);
        chk("rst_err", timeout_err_a, 0);
        rst = 1'b0;
        tick();

        // raw passthrough, echoing ADC with data = channel*100
        enable_b = 1'b1;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 40 && !b_if.cmd_valid; i++) tick();
            chk("b_cmd_valid", b_if.cmd_valid, 1);
            chk("b_cmd_channel", b_if.cmd_channel, 64'(1 + n % 4));
            b_if.cmd_ready = 1'b1;
            tick();
            b_if.cmd_ready = 1'b0;
            tick();
            b_if.rsp_valid   = 1'b1;
            b_if.rsp_channel = 5'(1 + n % 4);
            b_if.rsp_data    = 12'((1 + n % 4) * 100);
            tick();
            b_if.rsp_valid   = 1'b0;
            chk("b_strobe", ch_strobe_b, 64'(1 << (n % 4)));
            chk("b_scan_done", scan_done_b, 64'(n % 4 == 3));
        end
        chk("b_flat", adc_flat_b, 64'h0190_012C_00C8_0064);
        enable_b = 1'b0;

        // four samples on channel 1 -> one result of 100
        enable_a = 1'b1;
        a_sample(1, 10);
        a_sample(1, 20);
        a_sample(1, 30);
        chk("avg_no_early_strobe", ch_strobe_a, 0);
        a_sample(1, 40);
        chk("avg_strobe", ch_strobe_a, 3'b001);
        chk("avg_slot0", adc_flat_a[15:0], 100);
        tick();
        chk("avg_strobe_single", ch_strobe_a, 0);

        // command held off by the ADC
        for (int k = 0; k < 7; k++) begin
            chk("hold_valid", a_if.cmd_valid, 1);
            chk("hold_channel", a_if.cmd_channel, 2);
            tick();
        end

        // wrong-channel response ignored, matched ones accumulate
        a_accept(2);
        a_rsp(3, 999);
        chk("wrong_strobe", ch_strobe_a, 0);
        chk("wrong_still_wait", a_if.cmd_valid, 0);
        a_rsp(2, 5);
        a_sample(2, 5);
        a_sample(2, 5);
        a_sample(2, 5);
        chk("wrong_slot_strobe", ch_strobe_a, 3'b010);
        chk("wrong_slot1", adc_flat_a[31:16], 20);
        chk("wrong_slot0_hold", adc_flat_a[15:0], 100);

        // lost response: error after 16 WAIT cycles, same channel re-issued, partial sum dropped
        a_sample(3, 7);
        a_accept(3);
        repeat (15) tick();
        chk("tmo_err_before", timeout_err_a, 0);
        chk("tmo_still_wait", a_if.cmd_valid, 0);
        tick();
        chk("tmo_err_set", timeout_err_a, 1);
        a_wait_cmd(3);
        a_sample(3, 1);
        a_sample(3, 2);
        a_sample(3, 3);
        a_sample(3, 4);
        chk("tmo_strobe", ch_strobe_a, 3'b100);
        chk("tmo_scan_done", scan_done_a, 1);
        chk("tmo_slot2", adc_flat_a[47:32], 10);
        tick();
        chk("scan_done_pulse", scan_done_a, 0);
        chk("tmo_err_sticky", timeout_err_a, 1);
        err_clr_a = 1'b1;
        tick();
        err_clr_a = 1'b0;
        chk("err_cleared", timeout_err_a, 0);

        // response arriving on the timeout cycle wins
        a_accept(1);
        repeat (15) tick();
        a_rsp(1, 50);
        chk("race_no_err", timeout_err_a, 0);
        a_sample(1, 50);
        a_sample(1, 50);
        a_sample(1, 50);
        chk("race_strobe", ch_strobe_a, 3'b001);
        chk("race_slot0", adc_flat_a[15:0], 200);

        // timeout while err_clr held: set wins
        a_accept(2);
        err_clr_a = 1'b1;
        repeat (16) tick();
        chk("set_wins", timeout_err_a, 1);
        err_clr_a = 1'b0;

        // enable dropped mid-WAIT: command completes, then idle; resume keeps partial sum
        a_accept(2);
        enable_a = 1'b0;
        a_rsp(2, 9);
        for (int k = 0; k < 5; k++) begin
            chk("idle_no_cmd", a_if.cmd_valid, 0);
            tick();
        end
        chk("idle_slot1_hold", adc_flat_a[31:16], 20);
        enable_a = 1'b1;
        tick();
        a_wait_cmd(2);
        a_sample(2, 9);
        a_sample(2, 9);
        a_sample(2, 9);
        chk("resume_strobe", ch_strobe_a, 3'b010);
        chk("resume_slot1", adc_flat_a[31:16], 36);

        // reset in the middle of ISSUE
        a_wait_cmd(3);
        chk("pre_rst_err", timeout_err_a, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_cmd_valid", a_if.cmd_valid, 0);
        chk("mid_rst_cmd_channel", a_if.cmd_channel, 0);
        chk("mid_rst_flat", adc_flat_a, 0);
        chk("mid_rst_err", timeout_err_a, 0);
        chk("mid_rst_strobe", ch_strobe_a, 0);
        chk("mid_rst_scan_done", scan_done_a, 0);
        rst = 1'b0;
        tick();
        a_wait_cmd(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
